branch_recovery_ctrl: RTL and testbench

Sequences branch-misprediction recovery in the execute stage. It consumes the per-instruction prediction-correctness verdict and the resolved control-flow outcome, then:
- issues a single front-end redirect plus a timed IF/ID flush;
- trains the branch predictor through a one-entry valid/ready update buffer;
- back-pressures execute while recovery or training is pending;
- keeps saturating control-flow and mispredict performance counters.

---
 rtl/branch_recovery_ctrl.sv | 138 +++++++++++++
 tb/tb_branch_recovery_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_recovery_ctrl.sv
// Branch-misprediction recovery sequencer: one fetch redirect, a timed IF/ID flush,
// a one-entry predictor update buffer and saturating control-flow/mispredict counters.
module branch_recovery_ctrl #(
  parameter int ADDR_W       = 40,
  parameter int CNT_W        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              exe_valid_i,
  input  logic              exe_stall_i,
  input  logic              exe_is_ctrl_i,
  input  logic              exe_is_cond_i,
  input  logic              exe_taken_i,
  input  logic [ADDR_W-1:0] exe_pc_i,
  input  logic [ADDR_W-1:0] exe_next_pc_i,
  input  logic              correct_pred_i,
  input  logic              exc_flush_i,
  output logic              hold_exe_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              bp_upd_valid_o,
  input  logic              bp_upd_ready_i,
  output logic [ADDR_W-1:0] bp_upd_pc_o,
  output logic [ADDR_W-1:0] bp_upd_target_o,
  output logic              bp_upd_taken_o,
  output logic              bp_upd_cond_o,
  output logic              bp_upd_kill_o,
  output logic [CNT_W-1:0]  ctrl_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);

  // state | meaning
  // IDLE  | execute may resolve; waiting for a mispredict
  // FLUSH | flush_o held, redirect on first cycle, flush timer counting down
  // DRAIN | flush done, waiting for the predictor to accept the pending update
  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES - 1);

  state_t          state, state_nxt;
  logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
  logic            first, first_nxt;
  logic            capture;
  logic            resolve, mispred, load, accept, upd_valid_nxt;

  assign hold_exe_o    = (state != IDLE) | (bp_upd_valid_o & ~bp_upd_ready_i);
  assign resolve       = exe_valid_i & ~exe_stall_i & ~hold_exe_o & ~exc_flush_i;
  assign mispred       = resolve & ~correct_pred_i;
  assign load          = resolve & (exe_is_ctrl_i | ~correct_pred_i);
  assign accept        = bp_upd_valid_o & bp_upd_ready_i;
  assign upd_valid_nxt = load | (bp_upd_valid_o & ~accept);

  always_comb begin
    state_nxt        = state;
    flush_cnt_nxt    = flush_cnt;
    first_nxt        = 1'b0;
    capture          = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (mispred) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FC_INIT;
          first_nxt     = 1'b1;
          capture       = 1'b1;
        end
      end
      FLUSH: begin
        flush_o          = 1'b1;
        redirect_valid_o = first;
        if (flush_cnt == '0) begin
          state_nxt = upd_valid_nxt ? DRAIN : IDLE;
        end else begin
          flush_cnt_nxt = flush_cnt - FC_W'(1);
        end
      end
      DRAIN: begin
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A trap flush aborts recovery; the buffered training data stays valid.
    if (exc_flush_i) begin
      state_nxt     = IDLE;
      flush_cnt_nxt = '0;
      first_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      flush_cnt     <= '0;
      first         <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      first     <= first_nxt;
      if (capture) redirect_pc_o <= exe_next_pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bp_upd_valid_o  <= 1'b0;
      bp_upd_pc_o     <= '0;
      bp_upd_target_o <= '0;
      bp_upd_taken_o  <= 1'b0;
      bp_upd_cond_o   <= 1'b0;
      bp_upd_kill_o   <= 1'b0;
    end else begin
      bp_upd_valid_o <= upd_valid_nxt;
      if (load) begin
        bp_upd_pc_o     <= exe_pc_i;
        bp_upd_target_o <= exe_next_pc_i;
        bp_upd_taken_o  <= exe_taken_i;
        bp_upd_cond_o   <= exe_is_cond_i;
        bp_upd_kill_o   <= ~exe_is_ctrl_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_cnt_o    <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (resolve & exe_is_ctrl_i & ~&ctrl_cnt_o) ctrl_cnt_o <= ctrl_cnt_o + CNT_W'(1);
      if (mispred & ~&mispred_cnt_o) mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Bench for branch_recovery_ctrl: directed vector table, counter saturation,
// then randomized traffic checked against a cycle-level reference model.
module tb_branch_recovery_ctrl;
  localparam int ADDR_W = 40;
  localparam int CNT_W  = 4;
  localparam int FC     = 2;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, exe_valid, exe_stall, exe_is_ctrl, exe_is_cond, exe_taken;
  logic [ADDR_W-1:0] exe_pc, exe_next_pc;
  logic              correct_pred, exc_flush, bp_upd_ready;
  logic              hold_exe, flush, redirect_valid, bp_upd_valid;
  logic              bp_upd_taken, bp_upd_cond, bp_upd_kill;
  logic [ADDR_W-1:0] redirect_pc, bp_upd_pc, bp_upd_target;
  logic [CNT_W-1:0]  ctrl_cnt, mispred_cnt;

  branch_recovery_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .FLUSH_CYCLES(FC)) dut (
    .clk_i(clk), .rst_i(rst), .exe_valid_i(exe_valid), .exe_stall_i(exe_stall),
    .exe_is_ctrl_i(exe_is_ctrl), .exe_is_cond_i(exe_is_cond), .exe_taken_i(exe_taken),
    .exe_pc_i(exe_pc), .exe_next_pc_i(exe_next_pc), .correct_pred_i(correct_pred),
    .exc_flush_i(exc_flush), .hold_exe_o(hold_exe), .flush_o(flush),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .bp_upd_valid_o(bp_upd_valid), .bp_upd_ready_i(bp_upd_ready),
    .bp_upd_pc_o(bp_upd_pc), .bp_upd_target_o(bp_upd_target),
    .bp_upd_taken_o(bp_upd_taken), .bp_upd_cond_o(bp_upd_cond),
    .bp_upd_kill_o(bp_upd_kill), .ctrl_cnt_o(ctrl_cnt), .mispred_cnt_o(mispred_cnt));

  typedef struct {
    logic rst, valid, stall, ctrl, cond, taken, correct, exc, ready;
    logic [ADDR_W-1:0] pc, npc;
  } in_t;
  typedef struct {
    logic hold, flush, rv, uv, kill;
    logic [ADDR_W-1:0] rpc, upc;
    logic [CNT_W-1:0] cc, mc;
  } exp_t;
  typedef struct { in_t i; exp_t e; } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_mis = 0;
  bit   chk_model = 1'b0;

  // reference model: recovery expressed as "flush cycles remaining" plus a drain flag
  int                m_flush_left, m_cc, m_mc;
  bit                m_first, m_drain;
  bit                b_valid, b_taken, b_cond, b_kill;
  logic [ADDR_W-1:0] b_pc, b_tgt, m_rpc;

  // flags: rst valid stall ctrl cond taken correct exc ready
  function automatic in_t mi(input logic [8:0] f, input logic [ADDR_W-1:0] pc,
                             input logic [ADDR_W-1:0] npc);
    in_t v;
    {v.rst, v.valid, v.stall, v.ctrl, v.cond, v.taken, v.correct, v.exc, v.ready} = f;
    v.pc = pc;
    v.npc = npc;
    return v;
  endfunction

  function automatic in_t idle(input logic ready);
    return mi({8'b0, ready}, '0, '0);
  endfunction

  // flags: hold flush redirect_valid upd_valid upd_kill
  function automatic exp_t me(input logic [4:0] f, input logic [ADDR_W-1:0] rpc,
                              input logic [ADDR_W-1:0] upc, input logic [CNT_W-1:0] cc,
                              input logic [CNT_W-1:0] mc);
    exp_t e;
    {e.hold, e.flush, e.rv, e.uv, e.kill} = f;
    e.rpc = rpc;
    e.upc = upc;
    e.cc = cc;
    e.mc = mc;
    return e;
  endfunction

  function automatic void add(input in_t i, input exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0; m_first = 1'b0; m_drain = 1'b0; m_cc = 0; m_mc = 0;
    b_valid = 1'b0; b_taken = 1'b0; b_cond = 1'b0; b_kill = 1'b0;
    b_pc = '0; b_tgt = '0; m_rpc = '0;
  endtask

  task automatic model_step(input in_t v, input bit ehold);
    bit r, m, ld, acc;
    if (v.rst) begin
      model_reset();
      return;
    end
    r   = v.valid && !v.stall && !ehold && !v.exc;
    m   = r && !v.correct;
    ld  = r && (v.ctrl || !v.correct);
    acc = b_valid && v.ready;
    if (r && v.ctrl && m_cc < MAXC) m_cc++;
    if (m && m_mc < MAXC) m_mc++;
    if (ld) begin
      b_valid = 1'b1; b_pc = v.pc; b_tgt = v.npc;
      b_taken = v.taken; b_cond = v.cond; b_kill = !v.ctrl;
    end else if (acc) begin
      b_valid = 1'b0;
    end
    if (v.exc) begin
      m_flush_left = 0; m_first = 1'b0; m_drain = 1'b0;
    end else if (m) begin
      m_flush_left = FC; m_first = 1'b1; m_rpc = v.npc;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      m_first = 1'b0;
      if (m_flush_left == 0) m_drain = b_valid;
    end else if (m_drain && acc) begin
      m_drain = 1'b0;
    end
  endtask

  task automatic cycle(input in_t v, input bit has_exp, input exp_t e);
    bit ehold;
    rst = v.rst; exe_valid = v.valid; exe_stall = v.stall; exe_is_ctrl = v.ctrl;
    exe_is_cond = v.cond; exe_taken = v.taken; correct_pred = v.correct;
    exc_flush = v.exc; bp_upd_ready = v.ready; exe_pc = v.pc; exe_next_pc = v.npc;
    #1;
    ehold = (m_flush_left > 0) || m_drain || (b_valid && !v.ready);
    if (has_exp) begin
      chk("hold", 64'(hold_exe), 64'(e.hold));
      chk("flush", 64'(flush), 64'(e.flush));
      chk("redirect_valid", 64'(redirect_valid), 64'(e.rv));
      chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
      chk("upd_valid", 64'(bp_upd_valid), 64'(e.uv));
      chk("upd_pc", 64'(bp_upd_pc), 64'(e.upc));
      chk("upd_kill", 64'(bp_upd_kill), 64'(e.kill));
      chk("ctrl_cnt", 64'(ctrl_cnt), 64'(e.cc));
      chk("mispred_cnt", 64'(mispred_cnt), 64'(e.mc));
    end else if (chk_model) begin
      chk("m_hold", 64'(hold_exe), 64'(ehold));
      chk("m_flush", 64'(flush), 64'(m_flush_left > 0));
      chk("m_redirect_valid", 64'(redirect_valid), 64'(m_first));
      chk("m_redirect_pc", 64'(redirect_pc), 64'(m_rpc));
      chk("m_upd_valid", 64'(bp_upd_valid), 64'(b_valid));
      chk("m_upd_pc", 64'(bp_upd_pc), 64'(b_pc));
      chk("m_upd_target", 64'(bp_upd_target), 64'(b_tgt));
      chk("m_upd_taken", 64'(bp_upd_taken), 64'(b_taken));
      chk("m_upd_cond", 64'(bp_upd_cond), 64'(b_cond));
      chk("m_upd_kill", 64'(bp_upd_kill), 64'(b_kill));
      chk("m_ctrl_cnt", 64'(ctrl_cnt), 64'(m_cc));
      chk("m_mispred_cnt", 64'(mispred_cnt), 64'(m_mc));
    end
    model_step(v, ehold);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t ez;
    in_t  v;
    ez = me(5'b0, '0, '0, '0, '0);
    model_reset();

    // c0..c2 correct branch; c3..c7 mispredict; c8..c14 back-pressure/drain
    add(mi(9'b1_0_0_0_0_0_0_0_1, 40'h0, 40'h0),     me(5'b00000, 40'h0, 40'h0, 4'd0, 4'd0));
    add(mi(9'b0_1_0_1_1_1_1_0_1, 40'h100, 40'h180), me(5'b00000, 40'h0, 40'h0, 4'd0, 4'd0));
    add(idle(1'b1),                                 me(5'b00010, 40'h0, 40'h100, 4'd1, 4'd0));
    add(mi(9'b0_1_0_1_1_0_0_0_1, 40'h200, 40'h204), me(5'b00000, 40'h0, 40'h100, 4'd1, 4'd0));
    add(mi(9'b0_1_0_1_1_1_1_0_1, 40'h300, 40'h304), me(5'b11110, 40'h204, 40'h200, 4'd2, 4'd1));
    add(mi(9'b0_1_0_1_1_1_1_0_1, 40'h300, 40'h304), me(5'b11000, 40'h204, 40'h200, 4'd2, 4'd1));
    add(mi(9'b0_1_0_1_1_1_1_0_1, 40'h300, 40'h304), me(5'b00000, 40'h204, 40'h200, 4'd2, 4'd1));
    add(idle(1'b1),                                 me(5'b00010, 40'h204, 40'h300, 4'd3, 4'd1));
    add(mi(9'b0_1_0_1_1_1_0_0_0, 40'h400, 40'h480), me(5'b00000, 40'h204, 40'h300, 4'd3, 4'd1));
    add(idle(1'b0),                                 me(5'b11110, 40'h480, 40'h400, 4'd4, 4'd2));
    add(idle(1'b0),                                 me(5'b11010, 40'h480, 40'h400, 4'd4, 4'd2));
    add(idle(1'b0),                                 me(5'b10010, 40'h480, 40'h400, 4'd4, 4'd2));
    add(idle(1'b0),                                 me(5'b10010, 40'h480, 40'h400, 4'd4, 4'd2));
    add(idle(1'b1),                                 me(5'b10010, 40'h480, 40'h400, 4'd4, 4'd2));
    add(idle(1'b1),                                 me(5'b00000, 40'h480, 40'h400, 4'd4, 4'd2));
    // c15..c18 kill of a non-control instruction
    add(mi(9'b0_1_0_0_0_0_0_0_1, 40'h500, 40'h504), me(5'b00000, 40'h480, 40'h400, 4'd4, 4'd2));
    add(idle(1'b1),                                 me(5'b11111, 40'h504, 40'h500, 4'd4, 4'd3));
    add(idle(1'b1),                                 me(5'b11001, 40'h504, 40'h500, 4'd4, 4'd3));
    add(idle(1'b1),                                 me(5'b00001, 40'h504, 40'h500, 4'd4, 4'd3));
    // c19..c23 trap on first flush cycle, pending update still delivered
    add(mi(9'b0_1_0_1_1_1_0_0_0, 40'h600, 40'h680), me(5'b00001, 40'h504, 40'h500, 4'd4, 4'd3));
    add(mi(9'b0_0_0_0_0_0_0_1_0, 40'h0, 40'h0),     me(5'b11110, 40'h680, 40'h600, 4'd5, 4'd4));
    add(idle(1'b0),                                 me(5'b10010, 40'h680, 40'h600, 4'd5, 4'd4));
    add(idle(1'b1),                                 me(5'b00010, 40'h680, 40'h600, 4'd5, 4'd4));
    add(idle(1'b1),                                 me(5'b00000, 40'h680, 40'h600, 4'd5, 4'd4));
    // c24..c27 mispredict masked by a trap, then by a stall
    add(mi(9'b0_1_0_1_1_1_0_1_1, 40'h700, 40'h704), me(5'b00000, 40'h680, 40'h600, 4'd5, 4'd4));
    add(idle(1'b1),                                 me(5'b00000, 40'h680, 40'h600, 4'd5, 4'd4));
    add(mi(9'b0_1_1_1_1_1_0_0_1, 40'h800, 40'h804), me(5'b00000, 40'h680, 40'h600, 4'd5, 4'd4));
    add(idle(1'b1),                                 me(5'b00000, 40'h680, 40'h600, 4'd5, 4'd4));
    // c28..c33 reset while draining
    add(mi(9'b0_1_0_1_1_1_0_0_0, 40'h900, 40'h904), me(5'b00000, 40'h680, 40'h600, 4'd5, 4'd4));
    add(idle(1'b0),                                 me(5'b11110, 40'h904, 40'h900, 4'd6, 4'd5));
    add(idle(1'b0),                                 me(5'b11010, 40'h904, 40'h900, 4'd6, 4'd5));
    add(idle(1'b0),                                 me(5'b10010, 40'h904, 40'h900, 4'd6, 4'd5));
    add(mi(9'b1_0_0_0_0_0_0_0_0, 40'h0, 40'h0),     me(5'b10010, 40'h904, 40'h900, 4'd6, 4'd5));
    add(idle(1'b0),                                 me(5'b00000, 40'h0, 40'h0, 4'd0, 4'd0));

    @(posedge clk);
    #1;
    cycle(mi(9'b1_0_0_0_0_0_0_0_1, '0, '0), 1'b0, ez);
    cycle(mi(9'b1_0_0_0_0_0_0_0_1, '0, '0), 1'b0, ez);
    foreach (tbl[k]) cycle(tbl[k].i, 1'b1, tbl[k].e);

    chk_model = 1'b1;
    cycle(mi(9'b1_0_0_0_0_0_0_0_1, '0, '0), 1'b0, ez);
    for (int k = 0; k < 18; k++)
      cycle(mi(9'b0_1_0_1_1_1_1_0_1, ADDR_W'(k * 4), ADDR_W'(k * 4 + 64)), 1'b0, ez);
    cycle(idle(1'b1), 1'b0, ez);
    chk("ctrl_saturated", 64'(ctrl_cnt), 64'(MAXC));
    for (int k = 0; k < 60; k++)
      cycle(mi(9'b0_1_0_1_1_0_0_0_1, ADDR_W'(k * 8), ADDR_W'(k * 8 + 4)), 1'b0, ez);
    cycle(idle(1'b1), 1'b0, ez);
    chk("mispred_saturated", 64'(mispred_cnt), 64'(MAXC));
    chk("ctrl_still_saturated", 64'(ctrl_cnt), 64'(MAXC));

    cycle(mi(9'b1_0_0_0_0_0_0_0_1, '0, '0), 1'b0, ez);
    for (int k = 0; k < 3000; k++) begin
      v.rst     = ($urandom_range(0, 299) == 0);
      v.valid   = ($urandom_range(0, 9) < 7);
      v.stall   = ($urandom_range(0, 7) == 0);
      v.ctrl    = ($urandom_range(0, 3) != 0);
      v.cond    = 1'($urandom);
      v.taken   = 1'($urandom);
      v.correct = 1'($urandom);
      v.exc     = ($urandom_range(0, 11) == 0);
      v.ready   = ($urandom_range(0, 9) < 6);
      v.pc      = ADDR_W'({$urandom(), $urandom()});
      v.npc     = ADDR_W'({$urandom(), $urandom()});
      cycle(v, 1'b0, ez);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
